// File: rtl/rx_frame_ctrl_if.sv
// Byte-stream receive bus and host read port for rx_frame_ctrl.
interface rx_frame_ctrl_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       sof;
  logic       eof;
  logic       stop_err;
  logic       rd_en;
  logic [7:0] rd_data;

  modport master (output byte_in, byte_valid, sof, eof, stop_err, rd_en,
                  input  rd_data);
  modport slave  (input  byte_in, byte_valid, sof, eof, stop_err, rd_en,
                  output rd_data);
endinterface

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: frame FSM with running CRC-8 check, 8-deep byte FIFO,
// and next-value generation for the sticky status register plus interrupt.
module rx_frame_ctrl (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           status_q,
  input  logic                 txi_in,
  input  logic                 tbnf_in,
  output logic [7:0]           status_next,
  output logic                 irq,
  rx_frame_ctrl_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e     state_q, state_d;
  logic [7:0] crc_q, crc_d;
  logic [2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic [7:0] mem [8];
  logic       irq_q, irq_d;
  logic       en, push, push_ok, pop, full;
  logic       ev_fe, ev_crce, ev_or, ev_nf;

  // Polynomial 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign en = status_q[0];

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    push    = 1'b0;
    ev_fe   = 1'b0;
    ev_crce = 1'b0;
    ev_nf   = 1'b0;
    if (!en) begin
      state_d = IDLE;
      crc_d   = 8'h00;
    end else if (bus.byte_valid) begin
      if (bus.stop_err) begin
        ev_fe   = 1'b1;
        state_d = bus.eof ? IDLE : DROP;
      end else if (bus.sof && !bus.eof) begin
        // Restart out of DROP is silent; the error was already flagged on entry.
        ev_fe   = (state_q == RECV);
        state_d = RECV;
        crc_d   = crc8(8'h00, bus.byte_in);
        push    = 1'b1;
      end else if (bus.sof) begin
        ev_fe   = (state_q != DROP);
        state_d = IDLE;
      end else begin
        case (state_q)
          RECV: begin
            push  = 1'b1;
            crc_d = crc8(crc_q, bus.byte_in);
            if (bus.eof) begin
              state_d = IDLE;
              ev_nf   = (crc_d == 8'h00);
              ev_crce = (crc_d != 8'h00);
            end
          end
          DROP:    if (bus.eof) state_d = IDLE;
          default: begin
            ev_fe   = 1'b1;
            state_d = bus.eof ? IDLE : DROP;
          end
        endcase
      end
    end
  end

  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign full    = (count_q == 4'd8);
  assign pop     = en && bus.rd_en && (count_q != 4'd0);
  assign push_ok = push && (!full || pop);
  assign ev_or   = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {2'b00, push_ok};
    rd_ptr_d = rd_ptr_q + {2'b00, pop};
    count_d  = count_q + {3'b000, push_ok} - {3'b000, pop};
    if (!en) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
    end
  end

  always_comb begin
    if (!rst_n)
      status_next = {4'b0000, txi_in, tbnf_in, 1'b0, status_q[0]};
    else
      status_next = {status_q[7:4] | {ev_fe, ev_crce, ev_or, ev_nf},
                     txi_in, tbnf_in, (count_d != 4'd0), status_q[0]};
  end

  assign irq_d = en && ((|status_next[7:4]) || status_next[1] || status_next[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      crc_q    <= 8'h00;
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= bus.byte_in;
  end

  assign bus.rd_data = (count_q != 4'd0) ? mem[rd_ptr_q] : 8'h00;
  assign irq         = irq_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl; models the host status register around the DUT.
module tb_rx_frame_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txi = 1'b0, tbnf = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] clr = 8'h00;
  logic [7:0] stat = 8'h00;
  logic [7:0] status_next;
  logic       irq;
  int         tests = 0, fails = 0;

  rx_frame_ctrl_if bus ();

  rx_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .status_q    (stat),
    .txi_in      (txi),
    .tbnf_in     (tbnf),
    .status_next (status_next),
    .irq         (irq),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  // Host status register: loads status_next, host may clear sticky bits, owns ENA.
  always @(posedge clk) stat <= {status_next[7:1] & ~clr[7:1], ena};

  initial begin
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.sof = 1'b0;
    bus.eof = 1'b0; bus.stop_err = 1'b0; bus.rd_en = 1'b0;
  end

  task automatic send(input logic [7:0] b, input logic s, input logic e,
                      input logic se, input logic rd);
    bus.byte_in = b; bus.sof = s; bus.eof = e; bus.stop_err = se;
    bus.rd_en = rd; bus.byte_valid = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; bus.sof = 1'b0; bus.eof = 1'b0;
    bus.stop_err = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    @(posedge clk); #1;
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_status();
    clr = 8'hF0;
    @(posedge clk); #1;
    clr = 8'h00;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    txi = 1'b1; tbnf = 1'b1;
    repeat (2) @(posedge clk); #1;
    tests++; if (status_next !== 8'h0D) begin fails++;
      $display("FAIL reset_status_next got=%h exp=%h", status_next, 8'h0D); end
    tests++; if (irq !== 1'b0) begin fails++;
      $display("FAIL reset_irq got=%b exp=0", irq); end
    tests++; if (bus.rd_data !== 8'h00) begin fails++;
      $display("FAIL reset_rd_data got=%h exp=00", bus.rd_data); end
    @(negedge clk); rst_n = 1'b1; txi = 1'b0; tbnf = 1'b0;
    @(posedge clk); #1;
    tests++; if (stat !== 8'h01) begin fails++;
      $display("FAIL post_reset_status got=%h exp=01", stat); end
  endtask

  task automatic test_good_frame();
    logic [7:0] exp [3];
    exp = '{8'h31, 8'h32, 8'h72};
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0); send(8'h72, 0, 1, 0, 0);
    tests++; if (stat[7:4] !== 4'b0001) begin fails++;
      $display("FAIL good_events got=%b exp=0001", stat[7:4]); end
    tests++; if (stat[1] !== 1'b1 || irq !== 1'b1) begin fails++;
      $display("FAIL good_dr_irq got=%b%b exp=11", stat[1], irq); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.rd_data !== exp[i]) begin fails++;
        $display("FAIL good_pop%0d got=%h exp=%h", i, bus.rd_data, exp[i]); end
      pop();
    end
    tests++; if (stat[1] !== 1'b0 || bus.rd_data !== 8'h00) begin fails++;
      $display("FAIL good_empty got dr=%b data=%h exp dr=0 data=00", stat[1], bus.rd_data); end
    clear_status();
  endtask

  task automatic test_bad_crc();
    logic [7:0] exp [3];
    exp = '{8'h31, 8'h32, 8'h73};
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0); send(8'h73, 0, 1, 0, 0);
    tests++; if (stat[7:4] !== 4'b0100) begin fails++;
      $display("FAIL crc_events got=%b exp=0100", stat[7:4]); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.rd_data !== exp[i]) begin fails++;
        $display("FAIL crc_pop%0d got=%h exp=%h", i, bus.rd_data, exp[i]); end
      pop();
    end
    clear_status();
  endtask

  task automatic test_overrun();
    logic [7:0] exp [8];
    exp = '{8'h31, 8'h32, 8'h72, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0); send(8'h72, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) send(8'h00, 0, 0, 0, 0);
    send(8'h00, 0, 1, 0, 0);
    tests++; if (stat[7:4] !== 4'b0011) begin fails++;
      $display("FAIL ovr_events got=%b exp=0011", stat[7:4]); end
    tests++; if (stat[1] !== 1'b1 || irq !== 1'b1) begin fails++;
      $display("FAIL ovr_dr_irq got=%b%b exp=11", stat[1], irq); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus.rd_data !== exp[i]) begin fails++;
        $display("FAIL ovr_pop%0d got=%h exp=%h", i, bus.rd_data, exp[i]); end
      pop();
    end
    tests++; if (stat[1] !== 1'b0) begin fails++;
      $display("FAIL ovr_drained got dr=%b exp=0", stat[1]); end
    clear_status();
  endtask

  task automatic test_stop_err();
    logic [7:0] exp [4];
    exp = '{8'h31, 8'h31, 8'h32, 8'h72};
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 1, 0);
    tests++; if (stat[7] !== 1'b1) begin fails++;
      $display("FAIL stop_fe got=%b exp=1", stat[7]); end
    send(8'h55, 0, 0, 0, 0); send(8'h66, 0, 1, 0, 0);
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0); send(8'h72, 0, 1, 0, 0);
    tests++; if (stat[7:4] !== 4'b1001) begin fails++;
      $display("FAIL stop_events got=%b exp=1001", stat[7:4]); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.rd_data !== exp[i]) begin fails++;
        $display("FAIL stop_pop%0d got=%h exp=%h", i, bus.rd_data, exp[i]); end
      pop();
    end
    tests++; if (bus.rd_data !== 8'h00) begin fails++;
      $display("FAIL stop_empty got=%h exp=00", bus.rd_data); end
    clear_status();
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [8];
    exp = '{8'h32, 8'h72, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hAA};
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0); send(8'h72, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 0, 0, 0);
    send(8'hAA, 0, 0, 0, 1);
    tests++; if (stat[7:4] !== 4'b0000) begin fails++;
      $display("FAIL full_pp_events got=%b exp=0000", stat[7:4]); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (bus.rd_data !== exp[i]) begin fails++;
        $display("FAIL full_pp_pop%0d got=%h exp=%h", i, bus.rd_data, exp[i]); end
      pop();
    end
    tests++; if (bus.rd_data !== 8'h00 || stat[1] !== 1'b0) begin fails++;
      $display("FAIL full_pp_empty got data=%h dr=%b exp data=00 dr=0", bus.rd_data, stat[1]); end
    ena = 1'b0; repeat (2) @(posedge clk); #1;
    ena = 1'b1; @(posedge clk); #1;
    clear_status();
  endtask

  task automatic test_disable();
    send(8'h31, 1, 0, 0, 0); send(8'h32, 0, 0, 0, 0);
    ena = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests++; if (bus.rd_data !== 8'h00 || stat[1] !== 1'b0) begin fails++;
      $display("FAIL dis_flush got data=%h dr=%b exp data=00 dr=0", bus.rd_data, stat[1]); end
    tests++; if (irq !== 1'b0 || stat[0] !== 1'b0) begin fails++;
      $display("FAIL dis_irq_ena got irq=%b ena=%b exp 0 0", irq, stat[0]); end
    send(8'h77, 1, 0, 0, 0);
    tests++; if (stat[1] !== 1'b0 || stat[7:4] !== 4'b0000) begin fails++;
      $display("FAIL dis_ignore got=%h exp=00", stat); end
    ena = 1'b1; @(posedge clk); #1;
    send(8'h55, 0, 0, 0, 0);
    tests++; if (stat[7] !== 1'b1 || stat[1] !== 1'b0) begin fails++;
      $display("FAIL dis_idle got fe=%b dr=%b exp fe=1 dr=0", stat[7], stat[1]); end
    send(8'h66, 0, 1, 0, 0);
    clear_status();
  endtask

  task automatic test_reset_midframe();
    send(8'h31, 1, 0, 0, 0);
    @(negedge clk); rst_n = 1'b0; #2;
    tests++; if (status_next !== 8'h01 || irq !== 1'b0) begin fails++;
      $display("FAIL rst_mid got sn=%h irq=%b exp sn=01 irq=0", status_next, irq); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h32, 0, 0, 0, 0);
    tests++; if (stat[7] !== 1'b1 || stat[1] !== 1'b0) begin fails++;
      $display("FAIL rst_mid_fe got fe=%b dr=%b exp fe=1 dr=0", stat[7], stat[1]); end
    send(8'h66, 0, 1, 0, 0);
    clear_status();
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_good_frame();
        test_bad_crc();
        test_overrun();
        test_stop_err();
        test_full_push_pop();
        test_disable();
        test_reset_midframe();
      end
      begin
        #200000;
        fails++;
        $display("FAIL timeout got=running exp=done");
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Ports SHALL be as listed: name, direction, width, meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 status_q  in  8  current status register value (FE,CRCE,OR,NF,TXI,TBNF,DR,ENA in bits 7..0).
REQ-005 byte_in  in  8  received byte from deserializer.
REQ-006 byte_valid  in  1  byte_in valid this cycle (single-cycle strobe).
REQ-007 sof  in  1  qualifies byte_valid: first byte of frame.
REQ-008 eof  in  1  qualifies byte_valid: last byte of frame (the CRC byte).
REQ-009 stop_err  in  1  qualifies byte_valid: bad stop bit on this byte.
REQ-010 txi_in, tbnf_in  in  1 each  transmitter status, passed through to bits 3, 2.
REQ-011 rd_en  in  1  host pops one byte from receive FIFO.
REQ-012 rd_data  out  8  FIFO head byte, valid while DR=1.
REQ-013 status_next  out  8  combinational next value driven to the status register's internal input.
REQ-014 irq  out  1  registered interrupt request.

Function
REQ-015 Block SHALL be enabled when status_q[0]=1; when 0 it SHALL hold state IDLE, flush the FIFO, ignore byte_valid and rd_en.
REQ-016 States SHALL be IDLE, RECV, DROP; reset/disable -> IDLE.
REQ-017 IDLE: byte_valid&sof&~eof&~stop_err -> RECV, CRC reg = CRC8(0x00, byte), byte pushed.
REQ-018 IDLE: byte_valid without sof, or sof&eof together, SHALL raise FE event; without sof&eof -> DROP, else stay IDLE.
REQ-019 RECV: byte_valid&~eof pushes byte, updates CRC; byte_valid&eof pushes byte, computes final CRC, -> IDLE.
REQ-020 CRC SHALL be CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB first, over all bytes including CRC byte; final value 0x00 = good.
REQ-021 Frame end with final CRC 0x00 SHALL raise NF event; nonzero SHALL raise CRCE event.
REQ-022 RECV: byte_valid&sof (restart) SHALL raise FE and restart the frame as in REQ-017.
REQ-023 Any byte_valid&stop_err SHALL raise FE, discard the byte, and -> DROP (-> IDLE if eof).
REQ-024 DROP: discard bytes; byte_valid&eof -> IDLE; byte_valid&sof restarts per REQ-017 without a new FE.
REQ-025 FIFO SHALL be 8 entries x 8 bits, pointers 3 bits wrapping, count 0..8.
REQ-026 Push to full FIFO SHALL drop the byte and raise OR; frame CRC still updates.
REQ-027 rd_en with FIFO empty SHALL be ignored; simultaneous push and pop on full FIFO SHALL succeed both, count unchanged, no OR.
REQ-028 rd_data SHALL show mem[rd_ptr] combinationally; 0x00 when empty.
REQ-029 status_next[7:4] SHALL equal status_q[7:4] OR this cycle's FE,CRCE,OR,NF events (sticky; host clears via register).
REQ-030 status_next[3]=txi_in, [2]=tbnf_in, [1]=(count after this cycle's push/pop != 0), [0]=status_q[0].
REQ-031 Events SHALL appear in status_q one clock after the accepting byte_valid cycle.
REQ-032 irq SHALL register |status_next[7:4] | status_next[1] | status_next[3], forced 0 when disabled.

Reset
REQ-033 rst_n low SHALL asynchronously set state IDLE, CRC 0x00, pointers and count 0, irq 0.
REQ-034 During reset status_next SHALL be {4'b0, txi_in, tbnf_in, 1'b0, status_q[0]}.
REQ-035 Reset mid-frame SHALL discard the partial frame; the next byte without sof raises FE.

Verification
REQ-036 Frame 0x31(sof),0x32,CRC byte of {0x31,0x32} (eof) -> 3 bytes popped in order, NF set, CRCE=0.
REQ-037 Same frame with CRC byte XOR 0x01 -> CRCE set, NF=0, 3 bytes in FIFO.
REQ-038 10-byte good frame, no reads -> 8 bytes stored, OR set, DR=1, irq=1.
REQ-039 stop_err on second byte -> FE set, rest of frame discarded until eof, next sof frame accepted.
REQ-040 FIFO full, byte_valid and rd_en same cycle -> no OR, count stays 8, new byte at tail.
REQ-041 status_q[0]=0 mid-frame -> FIFO flushed, DR=0, state IDLE, irq=0.
